// File: rtl/bit_serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
//   state_t       : FSM encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   DEFAULT_WIDTH : default operand/sum width
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full-adder cell used by the bit-serial adder (purely combinational).
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out (majority of the three inputs)
module serial_add_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: {cout,sum} = a + b + cin, one bit per clock
// through a single full-adder cell and a registered carry.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, sampled only while idle
//   a, b, cin  : operands, captured when start is accepted
//   busy       : high while bits are being shifted
//   done       : one-cycle pulse; sum/cout valid from this cycle
//   sum, cout  : registered result, held until the next done
//   ovf        : signed overflow, present only when SERIAL_ADD_OVF_EN is defined
// Configuration macro: SERIAL_ADD_OVF_EN (adds the ovf output and its register).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic s_bit;
  logic c_nxt;

  serial_add_cell u_cell (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (s_bit),
    .c_o (c_nxt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        psum_d  = {s_bit, psum_q[WIDTH-1:1]};
        carry_d = c_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Result registers update only here, so partial sums never show.
          sum_d   = {s_bit, psum_q[WIDTH-1:1]};
          cout_d  = c_nxt;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final step.
          ovf_d   = carry_q ^ c_nxt;
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=8): handshake timing, result
// hold, ignored starts, reset abort, back-to-back spacing and random sums.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] s, input logic co, input logic ov);
    chk({tag, ".sum"}, sum, s);
    chk({tag, ".cout"}, cout, co);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, ".ovf"}, ovf, ov);
`else
    if (ov === 1'bx) $display("unexpected ov");
`endif
  endtask

  // Pulse start for one edge, then wait (bounded) for done.
  // lat counts edges after acceptance up to the done cycle; nb counts busy cycles.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        output int lat, output int nb);
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    lat = 0;
    nb  = int'(busy);
    while (!done && lat < 40) begin
      tick;
      lat++;
      nb += int'(busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, cyc, ndone;
    logic [W-1:0] ra, rb, low;
    logic         rc;
    logic [W:0]   full;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk_res("rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick;

    // 1: FF + 01 -> 00 carry 1
    run_op(8'hFF, 8'h01, 1'b0, lat, nb);
    chk("t1.lat", lat, W);
    chk("t1.busycyc", nb, W);
    chk_res("t1", 8'h00, 1'b1, 1'b0);
    tick;
    chk("t1.done_pulse", done, 0);
    chk("t1.idle_busy", busy, 0);
    chk_res("t1.hold", 8'h00, 1'b1, 1'b0);

    // 2: signed overflow cases
    run_op(8'h7F, 8'h01, 1'b0, lat, nb);
    chk_res("t2a", 8'h80, 1'b0, 1'b1);
    tick;
    run_op(8'h80, 8'h80, 1'b0, lat, nb);
    chk_res("t2b", 8'h00, 1'b1, 1'b1);
    tick;

    // 3: start pulse during SHIFT must be ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick;                         // E0
    start = 1'b0; a = '0; b = '0;
    cyc = 0;
    tick; cyc++;
    tick; cyc++;
    chk("t3.hold_midop", sum, 8'h00);
    a = 8'hFF; start = 1'b1;
    tick; cyc++;                  // E0+3
    start = 1'b0; a = '0;
    while (!done && cyc < 40) begin tick; cyc++; end
    chk("t3.lat", cyc, W);
    chk_res("t3", 8'h30, 1'b0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin tick; ndone += int'(done); end
    chk("t3.no_second_done", ndone, 0);
    chk("t3.result_held", sum, 8'h30);

    // 4: reset aborts an operation in flight
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick;                         // E0
    start = 1'b0; a = '0; b = '0;
    tick; tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("t4.busy", busy, 0);
    chk("t4.done", done, 0);
    chk_res("t4", 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin tick; ndone += int'(done); end
    chk("t4.no_done", ndone, 0);
    chk("t4.sum_zero", sum, 8'h00);

    // 5: FF + FF + 1, start held high for back-to-back ops
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    cyc = 0;
    do begin tick; cyc++; end while (!done && cyc < 40);
    chk_res("t5", 8'hFF, 1'b1, 1'b0);
    cyc = 0;
    do begin tick; cyc++; end while (!done && cyc < 40);
    start = 1'b0;
    chk("t5.spacing", cyc, W + 2);
    chk_res("t5.second", 8'hFF, 1'b1, 1'b0);
    tick;

    // 6: random operands against an arithmetic model
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      low  = {1'b0, ra[W-2:0]} + {1'b0, rb[W-2:0]} + {{(W-1){1'b0}}, rc};
      run_op(ra, rb, rc, lat, nb);
      chk("t6.lat", lat, W);
      chk_res("t6", full[W-1:0], full[W], low[W-1] ^ full[W]);
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
